// File: rtl/inst_queue.sv
// Instruction queue decoupling the fetch pipe register from decode.
// First-word fall-through FIFO with flush and address-exception halt.

package inst_queue_pkg;

    typedef struct packed {
        logic illegal;
        logic miss;
        logic invalid;
    } iaddr_ex_t;

    typedef struct packed {
        logic [31:0] vaddr;
        logic [31:0] inst;
        logic        valid;
        iaddr_ex_t   iaddr_ex;
    } pipe_if_t;

endpackage

module inst_queue
    import inst_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  pipe_if_t         pipe_if,
    input  logic             pipe_if_flush,
    output logic             ready_o,
    input  logic             deq_ready,
    output logic             deq_valid,
    output pipe_if_t         deq_inst,
    output logic [PTR_W:0]   count,
    output logic             ex_block
);

    localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

    pipe_if_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             enq;
    logic             deq;

    // Handshake outputs come from registered state only, so fetch sees no
    // combinational path from its own valid or from decode's ready.
    assign ready_o   = (count != FULL) & ~ex_block;
    assign deq_valid = (count != '0);
    assign enq       = pipe_if.valid & ready_o & ~pipe_if_flush;
    assign deq       = deq_valid & deq_ready & ~pipe_if_flush;

    always_comb begin
        // NOTE: default first so every path assigns deq_inst and no latch is inferred.
        deq_inst = '0;
        if (deq_valid) begin
            deq_inst       = mem[rd_ptr];
            deq_inst.valid = 1'b1;
        end
    end

    // NOTE: storage is not reset; occupancy tracking alone decides what is visible.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= pipe_if;
        end
    end

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || pipe_if_flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ex_block <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (pipe_if.iaddr_ex != '0) begin
                    ex_block <= 1'b1;
                end
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + {{PTR_W{1'b0}}, enq} - {{PTR_W{1'b0}}, deq};
        end
    end

    count_in_range : assert property (@(posedge clk) disable iff (rst) count <= FULL);

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: per-cycle vector table plus a wrap-around
// sequence checked against a small occupancy model and an expected-order queue.

module tb_inst_queue;
    import inst_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    pipe_if_t    pipe_if;
    logic        pipe_if_flush;
    logic        ready_o;
    logic        deq_ready;
    logic        deq_valid;
    pipe_if_t    deq_inst;
    logic [2:0]  count;
    logic        ex_block;

    int checks   = 0;
    int failures = 0;

    inst_queue dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_if       (pipe_if),
        .pipe_if_flush (pipe_if_flush),
        .ready_o       (ready_o),
        .deq_ready     (deq_ready),
        .deq_valid     (deq_valid),
        .deq_inst      (deq_inst),
        .count         (count),
        .ex_block      (ex_block)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic        flush;
        logic        valid;
        logic        dr;
        logic [31:0] vaddr;
        logic [2:0]  ex;
        logic        exp_ready;
        logic        exp_dv;
        int          exp_count;
        logic        exp_exb;
        logic [31:0] exp_vaddr;
        logic [2:0]  exp_ex;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic f, input logic v, input logic d,
                                input logic [31:0] va, input logic [2:0] e,
                                input logic er, input logic edv, input int ec,
                                input logic eexb, input logic [31:0] eva, input logic [2:0] eex);
        vec_t t;
        t.rst = r; t.flush = f; t.valid = v; t.dr = d; t.vaddr = va; t.ex = e;
        t.exp_ready = er; t.exp_dv = edv; t.exp_count = ec; t.exp_exb = eexb;
        t.exp_vaddr = eva; t.exp_ex = eex;
        return t;
    endfunction

    task automatic drive(input logic v, input logic [31:0] va, input logic [31:0] ins, input logic [2:0] e);
        pipe_if.vaddr    = va;
        pipe_if.inst     = ins;
        pipe_if.valid    = v;
        pipe_if.iaddr_ex = e;
    endtask

    initial begin
        rst = 1'b1; pipe_if_flush = 1'b0; deq_ready = 1'b0;
        drive(1'b0, '0, '0, '0);

        //          rst  fl   v    dr   vaddr         ex      rdy  dv   cnt exb  head_vaddr    head_ex
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,32'h0,       3'b000, 1'b1,1'b0,0, 1'b0,32'h0,       3'b000));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,32'h0,       3'b000, 1'b1,1'b0,0, 1'b0,32'h0,       3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,32'h0,       3'b000, 1'b1,1'b0,0, 1'b0,32'h0,       3'b000));
        // streaming, decode always ready
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,32'hbfc00000,3'b000, 1'b1,1'b1,1, 1'b0,32'hbfc00000,3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,32'hbfc00004,3'b000, 1'b1,1'b1,1, 1'b0,32'hbfc00004,3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,32'hbfc00008,3'b000, 1'b1,1'b1,1, 1'b0,32'hbfc00008,3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,32'h0,       3'b000, 1'b1,1'b0,0, 1'b0,32'h0,       3'b000));
        // fill and backpressure
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'hbfc00000,3'b000, 1'b1,1'b1,1, 1'b0,32'hbfc00000,3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'hbfc00004,3'b000, 1'b1,1'b1,2, 1'b0,32'hbfc00000,3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'hbfc00008,3'b000, 1'b1,1'b1,3, 1'b0,32'hbfc00000,3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'hbfc0000c,3'b000, 1'b0,1'b1,4, 1'b0,32'hbfc00000,3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'hbfc00010,3'b000, 1'b0,1'b1,4, 1'b0,32'hbfc00000,3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,32'hbfc00010,3'b000, 1'b1,1'b1,3, 1'b0,32'hbfc00004,3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'hbfc00010,3'b000, 1'b0,1'b1,4, 1'b0,32'hbfc00004,3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,32'h0,       3'b000, 1'b1,1'b1,3, 1'b0,32'hbfc00008,3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,32'h0,       3'b000, 1'b1,1'b1,2, 1'b0,32'hbfc0000c,3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,32'h0,       3'b000, 1'b1,1'b1,1, 1'b0,32'hbfc00010,3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,32'h0,       3'b000, 1'b1,1'b0,0, 1'b0,32'h0,       3'b000));
        // exception halt: third entry carries a miss
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h000000a0,3'b000, 1'b1,1'b1,1, 1'b0,32'h000000a0,3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h000000a4,3'b000, 1'b1,1'b1,2, 1'b0,32'h000000a0,3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h000000a8,3'b010, 1'b0,1'b1,3, 1'b1,32'h000000a0,3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h000000ac,3'b000, 1'b0,1'b1,3, 1'b1,32'h000000a0,3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,32'h000000ac,3'b000, 1'b0,1'b1,2, 1'b1,32'h000000a4,3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,32'h000000ac,3'b000, 1'b0,1'b1,1, 1'b1,32'h000000a8,3'b010));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,32'h000000ac,3'b000, 1'b0,1'b0,0, 1'b1,32'h0,       3'b000));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'h000000ac,3'b000, 1'b1,1'b0,0, 1'b0,32'h0,       3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h000000ac,3'b000, 1'b1,1'b1,1, 1'b0,32'h000000ac,3'b000));
        // flush colliding with enqueue and dequeue at count=3
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h000000b0,3'b000, 1'b1,1'b1,2, 1'b0,32'h000000ac,3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h000000b4,3'b000, 1'b1,1'b1,3, 1'b0,32'h000000ac,3'b000));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b1,32'h000000b8,3'b000, 1'b1,1'b0,0, 1'b0,32'h0,       3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,32'h0,       3'b000, 1'b1,1'b0,0, 1'b0,32'h0,       3'b000));
        // reset mid-stream wins over enqueue and dequeue
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h000000c0,3'b000, 1'b1,1'b1,1, 1'b0,32'h000000c0,3'b000));
        vecs.push_back(mk(1'b1,1'b0,1'b1,1'b1,32'h000000c4,3'b000, 1'b1,1'b0,0, 1'b0,32'h0,       3'b000));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,32'h0,       3'b000, 1'b1,1'b0,0, 1'b0,32'h0,       3'b000));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst           = vecs[i].rst;
            pipe_if_flush = vecs[i].flush;
            deq_ready     = vecs[i].dr;
            drive(vecs[i].valid, vecs[i].vaddr, ~vecs[i].vaddr, vecs[i].ex);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ready", i), 32'(ready_o), 32'(vecs[i].exp_ready));
            check($sformatf("v%0d_deq_valid", i), 32'(deq_valid), 32'(vecs[i].exp_dv));
            check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("v%0d_ex_block", i), 32'(ex_block), 32'(vecs[i].exp_exb));
            check($sformatf("v%0d_head_vaddr", i), deq_inst.vaddr, vecs[i].exp_vaddr);
            check($sformatf("v%0d_head_inst", i), deq_inst.inst,
                  vecs[i].exp_dv ? ~vecs[i].exp_vaddr : 32'h0);
            check($sformatf("v%0d_head_valid", i), 32'(deq_inst.valid), 32'(vecs[i].exp_dv));
            check($sformatf("v%0d_head_ex", i), 32'(deq_inst.iaddr_ex), 32'(vecs[i].exp_ex));
        end

        // Wrap-around: ten entries through a four-deep queue, decode ready every other cycle.
        begin
            logic [31:0] exp_q[$];
            int sent   = 0;
            int got    = 0;
            int mcount = 0;
            logic m_enq;
            logic m_deq;
            for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
                @(negedge clk);
                check("wrap_ready", 32'(ready_o), 32'(mcount != 4));
                check("wrap_count", 32'(count), 32'(mcount));
                rst           = 1'b0;
                pipe_if_flush = 1'b0;
                deq_ready     = cyc[0];
                drive(sent < 10, 32'hbfc01000 + 32'(sent * 4), 32'h24020000 + 32'(sent), 3'b000);
                m_enq = (sent < 10) && (mcount < 4);
                m_deq = (mcount > 0) && deq_ready;
                if (m_deq) begin
                    check("wrap_inst", deq_inst.inst, exp_q.pop_front());
                    got++;
                end
                if (m_enq) begin
                    exp_q.push_back(32'h24020000 + 32'(sent));
                    sent++;
                end
                mcount = mcount + int'(m_enq) - int'(m_deq);
            end
            check("wrap_all_dequeued", 32'(got), 32'd10);
            @(negedge clk);
            drive(1'b0, '0, '0, '0);
            deq_ready = 1'b0;
            check("wrap_final_count", 32'(count), 32'd0);
            check("wrap_final_valid", 32'(deq_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Decoupling FIFO between the instruction-fetch pipe register and the instruction-decode stage.
- Accepts one fetched instruction per cycle from the fetch stage's pipe_if output and drives back the fetch stage's ready_i.
- Presents the oldest buffered instruction to decode with a valid/ready handshake.
- Drops all contents on a fetch-pipe flush (branch taken or exception request). Stops accepting after an entry carrying an address exception.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), read/write pointer width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pipe_if  in  pipe_if_t (68)  fetch output: vaddr[31:0], inst[31:0], valid, iaddr_ex{illegal,miss,invalid}
- pipe_if_flush  in  1  flush from fetch stage (except_req.valid | resolved_branch.taken)
- ready_o  out  1  to fetch stage ready_i; queue can accept this cycle
- deq_ready  in  1  decode consumes head this cycle
- deq_valid  out  1  head entry present
- deq_inst  out  pipe_if_t (68)  head entry; valid field equals deq_valid
- count  out  PTR_W+1  current occupancy
- ex_block  out  1  an exception entry is buffered; enqueue is halted

Behaviour:
- Storage: DEPTH x 68-bit array, wr_ptr/rd_ptr PTR_W bits, wrap modulo DEPTH, count PTR_W+1 bits (0..DEPTH).
- Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, ex_block=0. Outputs after reset: deq_valid=0, deq_inst='0, ready_o=1, count=0, ex_block=0. Array contents are don't-care; deq_inst is masked to '0 whenever count==0.
- ready_o = (count != DEPTH) & ~ex_block. Depends on registered state only; no combinational path from pipe_if or deq_ready.
- Enqueue (enq) = pipe_if.valid & ready_o & ~pipe_if_flush. The entry is written at wr_ptr and wr_ptr increments.
  - On that same edge the fetch stage reloads its pipe register, so each fetch entry is accepted exactly once.
  - While ready_o=0 the fetch register holds its value; it is accepted the first cycle ready_o returns to 1.
- Dequeue (deq) = deq_valid & deq_ready & ~pipe_if_flush. rd_ptr increments.
- deq_valid = (count != 0). deq_inst = array[rd_ptr] (first-word fall-through). Latency from enqueue edge to deq_valid is 1 cycle.
- count_next = count + enq - deq.
  - Simultaneous enq and deq when 0 < count < DEPTH: count is unchanged.
  - Full: no enq, since ready_o=0. Deq allowed; ready_o rises the following cycle (no same-cycle full bypass).
  - Empty: no deq. Enq gives count=1 next cycle. No zero-cycle bypass to decode.
- Exception halt:
  - If an enqueued entry has iaddr_ex != 0, ex_block is set on that edge and ready_o drops next cycle.
  - Younger fetches are not accepted.
  - ex_block clears only on flush or rst. Entries ahead of the exception entry and the entry itself still drain to decode normally.
- Flush (pipe_if_flush=1 at posedge): wr_ptr=rd_ptr=0, count=0, ex_block=0. No enq and no deq on that edge, regardless of pipe_if.valid or deq_ready.
  - The pipe_if value present in the flush cycle is wrong-path and is discarded.
  - Priority: rst > flush > enq/deq.
- Reset or flush mid-stream: all buffered entries are lost. No partial state remains. ready_o=1 the next cycle.
- Invariant: count equals the number of enqueued minus dequeued entries since the last flush or reset. Assertion: count <= DEPTH.

Test Plan:
- Reset then idle: rst 2 cycles, pipe_if.valid=0 -> ready_o=1, deq_valid=0, count=0, deq_inst=0.
- Streaming: enqueue vaddr 0xbfc00000, 0xbfc00004, 0xbfc00008 with deq_ready=1 -> decode sees the three vaddrs in order, each 1 cycle after enqueue; count stays <=1.
- Fill/backpressure: deq_ready=0, enqueue 5 entries (DEPTH=4) -> count=4, ready_o=0 after the 4th. The 5th (vaddr 0xbfc00010) is held until one deq_ready pulse; it is enqueued the cycle after ready_o returns; output order is preserved.
- Wrap-around: 10 enqueue/dequeue pairs with alternating deq_ready -> pointers wrap past 3. Every inst value (0x24020000+i) is dequeued once, in order.
- Exception halt: third entry has iaddr_ex.miss=1 -> ex_block=1 and ready_o=0 next cycle. Entries 1-3 drain with the 3rd showing miss=1; the 4th is never accepted until pipe_if_flush, after which ex_block=0 and ready_o=1.
- Flush with simultaneous events: count=3, pipe_if.valid=1, deq_ready=1, pipe_if_flush=1 in the same cycle -> next cycle count=0, deq_valid=0. Neither the incoming entry nor the head is delivered.
